// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: pixel enable, h/v counters, active-low syncs, display flag.
// Optional VGA_FRAME_CNT_EN adds frame_tick / frame_cnt outputs.
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_TOTAL  = 800,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_ACTIVE = 640,
  parameter int V_TOTAL  = 525,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_ACTIVE = 480
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_en,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       hSync,
  output logic       vSync,
  output logic       bright
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic       frame_tick,
  output logic [7:0] frame_cnt
`endif
);

  localparam logic [3:0]  DIV_LAST     = 4'(CLK_DIV - 1);
  localparam logic [9:0]  H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST       = 10'(V_TOTAL - 1);
  // 11-bit bounds so a window ending exactly at 1024 still compares correctly
  localparam logic [10:0] H_SYNC_END   = 11'(H_SYNC);
  localparam logic [10:0] V_SYNC_END   = 11'(V_SYNC);
  localparam logic [10:0] H_DISP_START = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] H_DISP_END   = 11'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [10:0] V_DISP_START = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] V_DISP_END   = 11'(V_SYNC + V_BACK + V_ACTIVE);

  logic [3:0] r_div;
  logic       r_pix_en;
  logic [9:0] r_h_count;
  logic [9:0] r_v_count;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_bright;

  logic       w_pix_edge;
  logic       w_h_wrap;
  logic       w_v_wrap;
  logic [9:0] w_h_next;
  logic [9:0] w_v_next;
  logic       w_hsync_next;
  logic       w_vsync_next;
  logic       w_bright_next;

  always_comb begin
    w_pix_edge = (r_div == DIV_LAST);
    w_h_wrap   = (r_h_count == H_LAST);
    w_v_wrap   = (r_v_count == V_LAST);
    w_h_next   = w_h_wrap ? 10'd0 : r_h_count + 10'd1;
    w_v_next   = r_v_count;
    if (w_h_wrap) begin
      w_v_next = w_v_wrap ? 10'd0 : r_v_count + 10'd1;
    end
    // Decode from the next counter values so the registered flags line up with the counters.
    w_hsync_next  = !({1'b0, w_h_next} < H_SYNC_END);
    w_vsync_next  = !({1'b0, w_v_next} < V_SYNC_END);
    w_bright_next = ({1'b0, w_h_next} >= H_DISP_START) && ({1'b0, w_h_next} < H_DISP_END) &&
                    ({1'b0, w_v_next} >= V_DISP_START) && ({1'b0, w_v_next} < V_DISP_END);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div     <= 4'd0;
      r_pix_en  <= 1'b0;
      r_h_count <= 10'd0;
      r_v_count <= 10'd0;
      r_hsync   <= 1'b0;
      r_vsync   <= 1'b0;
      r_bright  <= 1'b0;
    end else begin
      r_pix_en <= w_pix_edge;
      r_div    <= w_pix_edge ? 4'd0 : r_div + 4'd1;
      if (w_pix_edge) begin
        r_h_count <= w_h_next;
        r_v_count <= w_v_next;
        r_hsync   <= w_hsync_next;
        r_vsync   <= w_vsync_next;
        r_bright  <= w_bright_next;
      end
    end
  end

  assign pix_en = r_pix_en;
  assign hCount = r_h_count;
  assign vCount = r_v_count;
  assign hSync  = r_hsync;
  assign vSync  = r_vsync;
  assign bright = r_bright;

`ifdef VGA_FRAME_CNT_EN
  logic       r_frame_tick;
  logic [7:0] r_frame_cnt;

  // Only a real frame wrap pulses; reset lands on (0,0) without a tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_tick <= 1'b0;
      r_frame_cnt  <= 8'd0;
    end else begin
      r_frame_tick <= w_pix_edge && w_h_wrap && w_v_wrap;
      if (w_pix_edge && w_h_wrap && w_v_wrap) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

  assign frame_tick = r_frame_tick;
  assign frame_cnt  = r_frame_cnt;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 instance plus a shrunken-raster
// instance (CLK_DIV=2) that makes frame wrap and visible-window edges reachable quickly.
module tb_vga_timing_gen;

  logic       clk;
  logic       rst;
  logic       rst_s;

  logic       pix_en,   hSync,   vSync,   bright;
  logic [9:0] hCount,   vCount;
  logic       pix_en_s, hSync_s, vSync_s, bright_s;
  logic [9:0] hCount_s, vCount_s;
`ifdef VGA_FRAME_CNT_EN
  logic       frame_tick,   frame_tick_s;
  logic [7:0] frame_cnt,    frame_cnt_s;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  vga_timing_gen u_dut (
    .clk    (clk),
    .rst    (rst),
    .pix_en (pix_en),
    .hCount (hCount),
    .vCount (vCount),
    .hSync  (hSync),
    .vSync  (vSync),
    .bright (bright)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_tick (frame_tick),
    .frame_cnt  (frame_cnt)
`endif
  );

  // Small raster: display h 4..9, v 3..6; frame = 12*8 pixels = 192 clks.
  vga_timing_gen #(
    .CLK_DIV (2),
    .H_TOTAL (12), .H_SYNC (2), .H_BACK (2), .H_ACTIVE (6),
    .V_TOTAL (8),  .V_SYNC (1), .V_BACK (2), .V_ACTIVE (4)
  ) u_small (
    .clk    (clk),
    .rst    (rst_s),
    .pix_en (pix_en_s),
    .hCount (hCount_s),
    .vCount (vCount_s),
    .hSync  (hSync_s),
    .vSync  (vSync_s),
    .bright (bright_s)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_tick (frame_tick_s),
    .frame_cnt  (frame_cnt_s)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_main(input string tag, input logic en, input int h, input int v,
                            input logic hs, input logic vs, input logic br);
    check({tag, " pix_en"}, 32'(pix_en), 32'(en));
    check({tag, " hCount"}, 32'(hCount), 32'(h));
    check({tag, " vCount"}, 32'(vCount), 32'(v));
    check({tag, " hSync"},  32'(hSync),  32'(hs));
    check({tag, " vSync"},  32'(vSync),  32'(vs));
    check({tag, " bright"}, 32'(bright), 32'(br));
  endtask

  task automatic check_small(input string tag, input logic en, input int h, input int v,
                             input logic hs, input logic vs, input logic br);
    check({tag, " pix_en"}, 32'(pix_en_s), 32'(en));
    check({tag, " hCount"}, 32'(hCount_s), 32'(h));
    check({tag, " vCount"}, 32'(vCount_s), 32'(v));
    check({tag, " hSync"},  32'(hSync_s),  32'(hs));
    check({tag, " vSync"},  32'(vSync_s),  32'(vs));
    check({tag, " bright"}, 32'(bright_s), 32'(br));
  endtask

  initial begin
    int cnt_hs, cnt_vs, cnt_br, cnt_en, cnt_ft;
    rst   = 1'b1;
    rst_s = 1'b1;

    // ---- default instance: reset, first pixel, hSync width, line wrap ----
    tick(5);
    check_main("reset", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
`ifdef VGA_FRAME_CNT_EN
    check("reset frame_tick", 32'(frame_tick), 32'd0);
    check("reset frame_cnt",  32'(frame_cnt),  32'd0);
`endif
    rst = 1'b0;                                   // k counts posedges from here
    tick(3);  check_main("k3 before edge", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    tick(1);  check_main("k4 first pixel", 1'b1, 1, 0, 1'b0, 1'b0, 1'b0);
    tick(1);  check_main("k5 hold",        1'b0, 1, 0, 1'b0, 1'b0, 1'b0);
    tick(378); check_main("k383 h95",      1'b0, 95, 0, 1'b0, 1'b0, 1'b0);
    tick(1);  check_main("k384 h96",       1'b1, 96, 0, 1'b1, 1'b0, 1'b0);
    tick(2815); check_main("k3199 h799",   1'b0, 799, 0, 1'b1, 1'b0, 1'b0);
    tick(1);  check_main("k3200 wrap",     1'b1, 0, 1, 1'b0, 1'b0, 1'b0);

    cnt_hs = 0; cnt_en = 0; cnt_br = 0;
    for (int i = 0; i < 3200; i++) begin
      if (hSync == 1'b0) cnt_hs++;
      if (pix_en)        cnt_en++;
      if (bright)        cnt_br++;
      tick(1);
    end
    check("line hSync low clks", 32'(cnt_hs), 32'd384);
    check("line pix_en count",   32'(cnt_en), 32'd800);
    check("line1 bright clks",   32'(cnt_br), 32'd0);
    check_main("k6400 line2",    1'b1, 0, 2, 1'b0, 1'b1, 1'b0);

    // ---- mid-line asynchronous reset during pix_en ----
    tick(1600); check_main("k8000 h400",   1'b1, 400, 2, 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    check_main("async reset", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    tick(2);
    rst = 1'b0;
    tick(4);  check_main("restart first pixel", 1'b1, 1, 0, 1'b0, 1'b0, 1'b0);

    // ---- small instance: CLK_DIV=2, visible window and frame wrap ----
    check_small("s reset", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    rst_s = 1'b0;
    tick(1);  check_small("s k1",         1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    tick(1);  check_small("s k2 h1",      1'b1, 1, 0, 1'b0, 1'b0, 1'b0);
    tick(1);  check_small("s k3 hold",    1'b0, 1, 0, 1'b0, 1'b0, 1'b0);
    tick(1);  check_small("s k4 h2",      1'b1, 2, 0, 1'b1, 1'b0, 1'b0);
    tick(20); check_small("s (0,1)",      1'b1, 0, 1, 1'b0, 1'b1, 1'b0);
    tick(32); check_small("s (4,2)",      1'b1, 4, 2, 1'b1, 1'b1, 1'b0);
    tick(22); check_small("s (3,3)",      1'b1, 3, 3, 1'b1, 1'b1, 1'b0);
    tick(2);  check_small("s (4,3)",      1'b1, 4, 3, 1'b1, 1'b1, 1'b1);
    tick(10); check_small("s (9,3)",      1'b1, 9, 3, 1'b1, 1'b1, 1'b1);
    tick(2);  check_small("s (10,3)",     1'b1, 10, 3, 1'b1, 1'b1, 1'b0);
    tick(70); check_small("s (9,6)",      1'b1, 9, 6, 1'b1, 1'b1, 1'b1);
    tick(14); check_small("s (4,7)",      1'b1, 4, 7, 1'b1, 1'b1, 1'b0);
    tick(14); check_small("s (11,7)",     1'b1, 11, 7, 1'b1, 1'b1, 1'b0);
`ifdef VGA_FRAME_CNT_EN
    check("s frame_cnt before wrap", 32'(frame_cnt_s), 32'd0);
`endif
    tick(2);  check_small("s frame wrap", 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);

    cnt_hs = 0; cnt_vs = 0; cnt_br = 0; cnt_en = 0; cnt_ft = 0;
    for (int i = 0; i < 192; i++) begin
      if (hSync_s == 1'b0) cnt_hs++;
      if (vSync_s == 1'b0) cnt_vs++;
      if (bright_s)        cnt_br++;
      if (pix_en_s)        cnt_en++;
`ifdef VGA_FRAME_CNT_EN
      if (frame_tick_s)    cnt_ft++;
      if (i == 0) check("s frame_cnt first wrap", 32'(frame_cnt_s), 32'd1);
      if (i == 1) check("s frame_tick one clk",   32'(frame_tick_s), 32'd0);
`endif
      tick(1);
    end
    check("s frame hSync low clks", 32'(cnt_hs), 32'd32);
    check("s frame vSync low clks", 32'(cnt_vs), 32'd24);
    check("s frame bright clks",    32'(cnt_br), 32'd48);
    check("s frame pix_en count",   32'(cnt_en), 32'd96);
`ifdef VGA_FRAME_CNT_EN
    check("s frame_tick per frame", 32'(cnt_ft), 32'd1);
    check("s frame_cnt k384",       32'(frame_cnt_s), 32'd2);
    tick(48767);
    check("s frame_cnt k49151",     32'(frame_cnt_s), 32'd255);
    check("s frame_tick k49151",    32'(frame_tick_s), 32'd0);
    tick(1);
    check("s frame_cnt wrap 256",   32'(frame_cnt_s), 32'd0);
    check("s frame_tick k49152",    32'(frame_tick_s), 32'd1);
`else
    check("s cnt_ft unused", 32'(cnt_ft), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
